expo_job_scheduler: RTL and testbench

- Shares one exponent FSMD core (computes a^n, 8-bit operands, 16-bit result) between two requesters with round-robin arbitration.
- Sequences the core: captures the winner's operands, pulses go, waits for done, then returns the result to the winner.
- Includes a watchdog that aborts and clears a hung core.
- Sits between the input sources (switch bank, auxiliary source) and the core; its status outputs feed the display logic.

---
 rtl/expo_job_scheduler_if.sv | 24 ++
 rtl/expo_job_scheduler.sv | 144 ++++++++++++++
 tb/tb_expo_job_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/expo_job_scheduler_if.sv
// Core-side link between the job scheduler (master) and the exponent core (slave).
// Handshake: go is a one-cycle start strobe with a/n stable from then on; a job is complete on the
// rising edge of done, when result is valid; clr aborts the core and has priority over everything else.
interface expo_job_scheduler_if #(
  parameter int DW = 8,
  parameter int RW = 16
);
  logic          core_go_o;
  logic [DW-1:0] core_a_o;
  logic [DW-1:0] core_n_o;
  logic          core_clr_o;
  logic          core_done_i;
  logic [RW-1:0] core_result_i;

  modport master (
    output core_go_o, core_a_o, core_n_o, core_clr_o,
    input  core_done_i, core_result_i
  );

  modport slave (
    input  core_go_o, core_a_o, core_n_o, core_clr_o,
    output core_done_i, core_result_i
  );
endinterface

// File: rtl/expo_job_scheduler.sv
// Round-robin sharing of one a^n core between two requesters, with a watchdog that aborts
// and clears a core that never signals completion.
module expo_job_scheduler #(
  parameter int DW      = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_i,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] n0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] n1_i,
  output logic [1:0]    done_o,
  output logic          err_o,
  output logic [RW-1:0] result_o,
  output logic [1:0]    grant_o,
  output logic          busy_o,
  output logic [7:0]    jobs_o,
  output logic [2:0]    state_o,
  expo_job_scheduler_if.master core
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ABORT1 = 3'd4,
    S_ABORT2 = 3'd5
  } state_t;

  // Last value the watchdog holds before the increment that reaches TIMEOUT.
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t        state_q;
  logic          last_grant_q;
  logic          done_prev_q;
  logic [TW-1:0] wd_q;
  logic [1:0]    grant_q;
  logic [1:0]    done_q;
  logic          err_q;
  logic [RW-1:0] result_q;
  logic [7:0]    jobs_q;
  logic          go_q;
  logic          clr_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] n_q;

  logic win_d;
  logic done_edge;

  always_comb begin
    win_d = 1'b0;
    if (req_i == 2'b10)      win_d = 1'b1;
    else if (req_i == 2'b11) win_d = ~last_grant_q;
  end

  // A done level left high by an earlier job must not complete the current one.
  assign done_edge = core.core_done_i & ~done_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      done_prev_q  <= 1'b0;
      wd_q         <= '0;
      grant_q      <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      result_q     <= '0;
      jobs_q       <= 8'd0;
      go_q         <= 1'b0;
      clr_q        <= 1'b0;
      a_q          <= '0;
      n_q          <= '0;
    end else begin
      done_prev_q <= core.core_done_i;
      go_q        <= 1'b0;
      done_q      <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (req_i != 2'b00) begin
            a_q          <= win_d ? a1_i : a0_i;
            n_q          <= win_d ? n1_i : n0_i;
            grant_q      <= win_d ? 2'b10 : 2'b01;
            last_grant_q <= win_d;
            go_q         <= 1'b1;
            wd_q         <= '0;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (done_edge) begin
            result_q <= core.core_result_i;
            done_q   <= grant_q;
            err_q    <= 1'b0;
            jobs_q   <= jobs_q + 8'd1;
            state_q  <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST) begin
              clr_q   <= 1'b1;
              state_q <= S_ABORT1;
            end
          end
        end
        S_DONE: begin
          grant_q <= 2'b00;
          state_q <= S_IDLE;
        end
        S_ABORT1: begin
          done_q   <= grant_q;
          err_q    <= 1'b1;
          result_q <= '0;
          jobs_q   <= jobs_q + 8'd1;
          state_q  <= S_ABORT2;
        end
        S_ABORT2: begin
          clr_q   <= 1'b0;
          grant_q <= 2'b00;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done_o          = done_q;
  assign err_o           = err_q;
  assign result_o        = result_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != S_IDLE);
  assign jobs_o          = jobs_q;
  assign state_o         = state_q;
  assign core.core_go_o  = go_q;
  assign core.core_a_o   = a_q;
  assign core.core_n_o   = n_q;
  assign core.core_clr_o = clr_q;

endmodule

// File: tb/tb_expo_job_scheduler.sv
// Directed bench for expo_job_scheduler with a behavioural a^n core of programmable latency.
module tb_expo_job_scheduler;
  localparam int DW = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_i;
  logic [DW-1:0] a0_i, n0_i, a1_i, n1_i;
  logic [1:0]    done_o;
  logic          err_o;
  logic [RW-1:0] result_o;
  logic [1:0]    grant_o;
  logic          busy_o;
  logic [7:0]    jobs_o;
  logic [2:0]    state_o;

  expo_job_scheduler_if #(.DW(DW), .RW(RW)) core_if ();

  expo_job_scheduler #(.DW(DW), .RW(RW), .TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .rst(rst), .req_i(req_i),
    .a0_i(a0_i), .n0_i(n0_i), .a1_i(a1_i), .n1_i(n1_i),
    .done_o(done_o), .err_o(err_o), .result_o(result_o), .grant_o(grant_o),
    .busy_o(busy_o), .jobs_o(jobs_o), .state_o(state_o), .core(core_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Core model: done drops at go (unless core_keep), dips low one cycle before finishing, rises at core_lat.
  int            core_lat  = 12;
  bit            core_hang = 1'b0;
  bit            core_keep = 1'b0;
  int            core_cnt;
  bit            core_run;
  logic [DW-1:0] core_a, core_n;
  int            go_cnt = 0;

  function automatic logic [RW-1:0] pow_fn(input logic [DW-1:0] a, input logic [DW-1:0] n);
    logic [RW-1:0] r;
    r = 1;
    for (int i = 0; i < int'(n); i++) r = r * RW'(a);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_run              <= 1'b0;
      core_cnt              <= 0;
      core_if.core_done_i   <= 1'b0;
      core_if.core_result_i <= '0;
    end else if (core_if.core_clr_o) begin
      core_run            <= 1'b0;
      core_if.core_done_i <= 1'b0;
    end else if (core_if.core_go_o) begin
      go_cnt   <= go_cnt + 1;
      core_run <= 1'b1;
      core_cnt <= 0;
      core_a   <= core_if.core_a_o;
      core_n   <= core_if.core_n_o;
      if (!core_keep) core_if.core_done_i <= 1'b0;
    end else if (core_run && !core_hang) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == core_lat - 1) core_if.core_done_i <= 1'b0;
      if (core_cnt + 1 == core_lat) begin
        core_if.core_done_i   <= 1'b1;
        core_if.core_result_i <= pow_fn(core_a, core_n);
        core_run              <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if (grant_o === 2'b11 || done_o === 2'b11) begin
        errors++;
        $display("FAIL onehot grant=%b done=%b exp neither 11", grant_o, done_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_i = 2'b00;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < max_cyc) begin
      step();
      cyc++;
      if (done_o != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 2'b00;
    a0_i = 8'd0; n0_i = 8'd0; a1_i = 8'd0; n1_i = 8'd0;
    repeat (2) step();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_o); end
    checks++; if (busy_o !== 1'b0 || grant_o !== 2'b00 || done_o !== 2'b00) begin errors++; $display("FAIL rst_ctrl got busy=%b grant=%b done=%b exp 0", busy_o, grant_o, done_o); end
    checks++; if (jobs_o !== 8'd0 || result_o !== 16'h0000 || err_o !== 1'b0) begin errors++; $display("FAIL rst_data got jobs=%0d res=%h err=%b exp 0", jobs_o, result_o, err_o); end
    checks++; if (core_if.core_go_o !== 1'b0 || core_if.core_clr_o !== 1'b0 || core_if.core_a_o !== 8'd0 || core_if.core_n_o !== 8'd0) begin errors++; $display("FAIL rst_core got go=%b clr=%b a=%h n=%h exp 0", core_if.core_go_o, core_if.core_clr_o, core_if.core_a_o, core_if.core_n_o); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    int cyc; bit ok; int go0;
    go0 = go_cnt;
    a0_i = 8'd3; n0_i = 8'd4; req_i = 2'b01;
    step();
    checks++; if (core_if.core_go_o !== 1'b1 || grant_o !== 2'b01) begin errors++; $display("FAIL single_launch got go=%b grant=%b exp 1/01", core_if.core_go_o, grant_o); end
    checks++; if (core_if.core_a_o !== 8'd3 || core_if.core_n_o !== 8'd4) begin errors++; $display("FAIL single_ops got a=%0d n=%0d exp 3/4", core_if.core_a_o, core_if.core_n_o); end
    a0_i = 8'd9; n0_i = 8'd9;
    wait_done(40, cyc, ok);
    checks++; if (!ok || cyc != 14) begin errors++; $display("FAIL single_latency got ok=%b cyc=%0d exp 14", ok, cyc); end
    checks++; if (done_o !== 2'b01 || err_o !== 1'b0 || result_o !== 16'h0051) begin errors++; $display("FAIL single_done got done=%b err=%b res=%h exp 01/0/0051", done_o, err_o, result_o); end
    checks++; if (jobs_o !== 8'd1 || core_if.core_a_o !== 8'd3) begin errors++; $display("FAIL single_jobs got jobs=%0d a=%0d exp 1/3", jobs_o, core_if.core_a_o); end
    req_i = 2'b00;
    step();
    checks++; if (done_o !== 2'b00 || grant_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL single_idle got done=%b grant=%b busy=%b exp 0", done_o, grant_o, busy_o); end
    checks++; if (go_cnt - go0 != 1) begin errors++; $display("FAIL single_gocount got %0d exp 1", go_cnt - go0); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok;
    do_reset();
    a0_i = 8'd2; n0_i = 8'd3; a1_i = 8'd5; n1_i = 8'd2; req_i = 2'b11;
    step();
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL tie_first got %b exp 01", grant_o); end
    wait_done(40, cyc, ok);
    checks++; if (!ok || done_o !== 2'b01 || result_o !== 16'h0008) begin errors++; $display("FAIL tie_done0 got done=%b res=%h exp 01/0008", done_o, result_o); end
    req_i = 2'b10;
    step();
    checks++; if (grant_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got grant=%b busy=%b exp 00/0", grant_o, busy_o); end
    step();
    checks++; if (grant_o !== 2'b10 || core_if.core_go_o !== 1'b1 || core_if.core_a_o !== 8'd5) begin errors++; $display("FAIL b2b_grant1 got grant=%b go=%b a=%0d exp 10/1/5", grant_o, core_if.core_go_o, core_if.core_a_o); end
    wait_done(40, cyc, ok);
    checks++; if (!ok || done_o !== 2'b10 || err_o !== 1'b0 || result_o !== 16'h0019) begin errors++; $display("FAIL tie_done1 got done=%b err=%b res=%h exp 10/0/0019", done_o, err_o, result_o); end
    checks++; if (jobs_o !== 8'd2) begin errors++; $display("FAIL tie_jobs got %0d exp 2", jobs_o); end
    req_i = 2'b00;
    step();
  endtask

  task automatic test_fairness();
    int cyc; bit ok;
    logic [1:0]    exp_g;
    logic [RW-1:0] exp_r;
    do_reset();
    a0_i = 8'd3; n0_i = 8'd2; a1_i = 8'd2; n1_i = 8'd5; req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (k % 2 == 0) ? 16'd9 : 16'd32;
      wait_done(40, cyc, ok);
      if (k == 3) req_i = 2'b00;
      checks++; if (!ok || done_o !== exp_g || result_o !== exp_r) begin errors++; $display("FAIL fair_job%0d got done=%b res=%h exp %b/%h", k, done_o, result_o, exp_g, exp_r); end
    end
    checks++; if (jobs_o !== 8'd4) begin errors++; $display("FAIL fair_jobs got %0d exp 4", jobs_o); end
    step();
  endtask

  task automatic test_stale_done();
    int cyc; bit ok; bit early;
    core_keep = 1'b1;
    a0_i = 8'd4; n0_i = 8'd3; req_i = 2'b01;
    step();
    early = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (done_o != 2'b00) early = 1'b1;
    end
    checks++; if (early !== 1'b0 || state_o !== 3'd2) begin errors++; $display("FAIL stale_ignored got early=%b state=%0d exp 0/2", early, state_o); end
    wait_done(40, cyc, ok);
    checks++; if (!ok || cyc != 3) begin errors++; $display("FAIL stale_edge got ok=%b cyc=%0d exp 3", ok, cyc); end
    checks++; if (done_o !== 2'b01 || result_o !== 16'h0040 || jobs_o !== 8'd5) begin errors++; $display("FAIL stale_done got done=%b res=%h jobs=%0d exp 01/0040/5", done_o, result_o, jobs_o); end
    req_i = 2'b00;
    core_keep = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    int n; bit seen;
    core_hang = 1'b1;
    a1_i = 8'd7; n1_i = 8'd1; req_i = 2'b10;
    step();
    checks++; if (grant_o !== 2'b10 || core_if.core_go_o !== 1'b1) begin errors++; $display("FAIL wd_launch got grant=%b go=%b exp 10/1", grant_o, core_if.core_go_o); end
    n = 0; seen = 1'b0;
    while (n < 40 && !seen) begin
      step();
      n++;
      if (core_if.core_clr_o === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || n != 17 || done_o !== 2'b00) begin errors++; $display("FAIL wd_abort got seen=%b cyc=%0d done=%b exp 1/17/00", seen, n, done_o); end
    req_i = 2'b00;
    step();
    checks++; if (core_if.core_clr_o !== 1'b1 || done_o !== 2'b10 || err_o !== 1'b1) begin errors++; $display("FAIL wd_done got clr=%b done=%b err=%b exp 1/10/1", core_if.core_clr_o, done_o, err_o); end
    checks++; if (result_o !== 16'h0000 || jobs_o !== 8'd6) begin errors++; $display("FAIL wd_data got res=%h jobs=%0d exp 0000/6", result_o, jobs_o); end
    step();
    checks++; if (core_if.core_clr_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 2'b00 || grant_o !== 2'b00) begin errors++; $display("FAIL wd_idle got clr=%b busy=%b done=%b grant=%b exp 0", core_if.core_clr_o, busy_o, done_o, grant_o); end
    core_hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; bit spurious;
    a0_i = 8'd3; n0_i = 8'd3; req_i = 2'b01;
    step();
    repeat (5) step();
    checks++; if (state_o !== 3'd2 || busy_o !== 1'b1) begin errors++; $display("FAIL mid_inwait got state=%0d busy=%b exp 2/1", state_o, busy_o); end
    rst = 1'b0; req_i = 2'b00;
    #1;
    checks++; if (busy_o !== 1'b0 || grant_o !== 2'b00 || jobs_o !== 8'd0 || core_if.core_a_o !== 8'd0 || state_o !== 3'd0) begin errors++; $display("FAIL mid_async got busy=%b grant=%b jobs=%0d a=%0d state=%0d exp 0", busy_o, grant_o, jobs_o, core_if.core_a_o, state_o); end
    #2 rst = 1'b1;
    spurious = 1'b0;
    repeat (20) begin
      step();
      if (done_o != 2'b00 || busy_o != 1'b0) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL mid_nodone got %b exp 0", spurious); end
    a1_i = 8'd3; n1_i = 8'd5; req_i = 2'b10;
    step();
    checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL mid_grant got %b exp 10", grant_o); end
    wait_done(40, cyc, ok);
    checks++; if (!ok || done_o !== 2'b10 || result_o !== 16'h00F3 || jobs_o !== 8'd1) begin errors++; $display("FAIL mid_job got done=%b res=%h jobs=%0d exp 10/00F3/1", done_o, result_o, jobs_o); end
    req_i = 2'b00;
    step();
  endtask

  initial begin
    rst = 1'b1;
    req_i = 2'b00;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_stale_done();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
